// File: rtl/rs_pkg.sv
// rs_pkg: shared widths, tag constant and entry record for the reservation station bank.
package rs_pkg;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int PC_W   = 10;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;
    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} state_e;
    typedef struct packed {
        state_e             state;
        logic [OP_W-1:0]    op;
        logic [DATA_W-1:0]  vj;
        logic [DATA_W-1:0]  vk;
        logic [TAG_W-1:0]   qj;
        logic [TAG_W-1:0]   qk;
        logic [PC_W-1:0]    pc;
    } entry_t;
endpackage

// File: rtl/rs_bank_if.sv
// rs_bank_if: issue/CDB/FU/done bundle of the reservation station bank.
// RS_FLUSH_EN adds the flush signal.
interface rs_bank_if import rs_pkg::*; #(parameter int DEPTH = 4) ();
    logic                         alloc_valid, alloc_ready;
    logic [OP_W-1:0]              alloc_op;
    logic [DATA_W-1:0]            alloc_vj, alloc_vk;
    logic [TAG_W-1:0]             alloc_qj, alloc_qk, alloc_tag;
    logic [PC_W-1:0]              alloc_pc;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [DATA_W-1:0]            cdb_data;
    logic                         issue_valid, issue_ready;
    logic [OP_W-1:0]              issue_op;
    logic [DATA_W-1:0]            issue_v1, issue_v2;
    logic [TAG_W-1:0]             issue_tag;
    logic [PC_W-1:0]              issue_pc;
    logic                         done_valid;
    logic [TAG_W-1:0]             done_tag;
    logic [DEPTH-1:0]             busy_vec;
    logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef RS_FLUSH_EN
    logic                         flush;
    modport master (output alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk, alloc_pc,
                    cdb_valid, cdb_tag, cdb_data, issue_ready, done_valid, done_tag, flush,
                    input alloc_ready, alloc_tag, issue_valid, issue_op, issue_v1, issue_v2,
                    issue_tag, issue_pc, busy_vec, count);
    modport slave  (input alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk, alloc_pc,
                    cdb_valid, cdb_tag, cdb_data, issue_ready, done_valid, done_tag, flush,
                    output alloc_ready, alloc_tag, issue_valid, issue_op, issue_v1, issue_v2,
                    issue_tag, issue_pc, busy_vec, count);
`else
    modport master (output alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk, alloc_pc,
                    cdb_valid, cdb_tag, cdb_data, issue_ready, done_valid, done_tag,
                    input alloc_ready, alloc_tag, issue_valid, issue_op, issue_v1, issue_v2,
                    issue_tag, issue_pc, busy_vec, count);
    modport slave  (input alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk, alloc_pc,
                    cdb_valid, cdb_tag, cdb_data, issue_ready, done_valid, done_tag,
                    output alloc_ready, alloc_tag, issue_valid, issue_op, issue_v1, issue_v2,
                    issue_tag, issue_pc, busy_vec, count);
`endif
endinterface

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: r_age[i][j]=1 means entry i is older than entry j; picks the oldest requester.
module rs_age_matrix #(parameter int N = 4) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [N-1:0] i_alloc,
    input  logic [N-1:0] i_free,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_oldest
);
    logic [N-1:0] r_age [N];
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < N; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i_alloc[i] || i_free[i]) r_age[i][j] <= 1'b0;
                    else if (i_alloc[j] && i != j) r_age[i][j] <= 1'b1;
        end
    end
    always_comb begin
        o_oldest = i_req;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i_req[j] && r_age[j][i]) o_oldest[i] = 1'b0;
    end
endmodule

// File: rtl/rs_bank.sv
// rs_bank: DEPTH-entry add/sub reservation station with CDB snoop and oldest-ready dispatch.
// RS_FLUSH_EN enables the flush input.
module rs_bank import rs_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int ID_BASE = 1
) (
    input logic        CLK,
    input logic        CLR,
    rs_bank_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    entry_t               r_ent [DEPTH];
    logic [DEPTH-1:0]     w_busy, w_ready, w_alloc, w_free, w_oldest, w_issue, w_wj, w_wk;
    logic                 w_flush, w_full, w_take, w_bj, w_bk;
    logic [IDX_W-1:0]     w_free_idx;
    logic [CNT_W-1:0]     w_count;
    logic [DATA_W-1:0]    w_avj, w_avk, w_v1, w_v2;
    logic [TAG_W-1:0]     w_aqj, w_aqk, w_tag;
    logic [OP_W-1:0]      w_op;
    logic [PC_W-1:0]      w_pc;
`ifdef RS_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif
    always_comb begin
        w_count    = '0;
        w_free_idx = '0;
        w_full     = 1'b1;
        for (int i = DEPTH-1; i >= 0; i--) begin
            w_busy[i]  = r_ent[i].state != ST_FREE;
            w_ready[i] = r_ent[i].state == ST_READY;
            w_wj[i]    = bus.cdb_valid && r_ent[i].qj != TAG_NONE && bus.cdb_tag == r_ent[i].qj;
            w_wk[i]    = bus.cdb_valid && r_ent[i].qk != TAG_NONE && bus.cdb_tag == r_ent[i].qk;
            w_free[i]  = w_flush || (bus.done_valid && r_ent[i].state == ST_ISSUED &&
                                     bus.done_tag == TAG_W'(ID_BASE + i));
            w_count    = w_count + CNT_W'(w_busy[i]);
            if (!w_busy[i]) begin
                w_free_idx = IDX_W'(i);
                w_full     = 1'b0;
            end
        end
    end
    assign w_take  = bus.alloc_valid && !w_full && !w_flush;
    assign w_alloc = w_take ? DEPTH'(1) << w_free_idx : '0;
    // A producer broadcasting on the allocation edge is captured directly.
    assign w_bj  = bus.cdb_valid && bus.alloc_qj != TAG_NONE && bus.cdb_tag == bus.alloc_qj;
    assign w_bk  = bus.cdb_valid && bus.alloc_qk != TAG_NONE && bus.cdb_tag == bus.alloc_qk;
    assign w_avj = w_bj ? bus.cdb_data : bus.alloc_vj;
    assign w_avk = w_bk ? bus.cdb_data : bus.alloc_vk;
    assign w_aqj = w_bj ? TAG_NONE : bus.alloc_qj;
    assign w_aqk = w_bk ? TAG_NONE : bus.alloc_qk;
    rs_age_matrix #(.N(DEPTH)) u_age (
        .CLK(CLK), .CLR(CLR), .i_alloc(w_alloc), .i_free(w_free),
        .i_req(w_ready), .o_oldest(w_oldest)
    );
    always_comb begin
        w_op  = '0;
        w_v1  = '0;
        w_v2  = '0;
        w_pc  = '0;
        w_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_op  = w_op  | (w_oldest[i] ? r_ent[i].op : '0);
            w_v1  = w_v1  | (w_oldest[i] ? r_ent[i].vj : '0);
            w_v2  = w_v2  | (w_oldest[i] ? r_ent[i].vk : '0);
            w_pc  = w_pc  | (w_oldest[i] ? r_ent[i].pc : '0);
            w_tag = w_tag | (w_oldest[i] ? TAG_W'(ID_BASE + i) : '0);
        end
    end
    assign w_issue         = (bus.issue_ready && !w_flush) ? w_oldest : '0;
    assign bus.issue_valid = |w_ready;
    assign bus.issue_op    = w_op;
    assign bus.issue_v1    = w_v1;
    assign bus.issue_v2    = w_v2;
    assign bus.issue_pc    = w_pc;
    assign bus.issue_tag   = w_tag;
    assign bus.alloc_ready = !w_full;
    assign bus.alloc_tag   = TAG_W'(ID_BASE + int'(w_free_idx));
    assign bus.busy_vec    = w_busy;
    assign bus.count       = w_count;
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (w_free[i]) r_ent[i].state <= ST_FREE;
                else if (w_alloc[i])
                    r_ent[i] <= '{state: (w_aqj != TAG_NONE || w_aqk != TAG_NONE) ? ST_WAIT : ST_READY,
                                  op: bus.alloc_op, vj: w_avj, vk: w_avk, qj: w_aqj, qk: w_aqk,
                                  pc: bus.alloc_pc};
                else if (w_issue[i]) r_ent[i].state <= ST_ISSUED;
                else if (r_ent[i].state == ST_WAIT) begin
                    if (w_wj[i]) begin
                        r_ent[i].vj <= bus.cdb_data;
                        r_ent[i].qj <= TAG_NONE;
                    end
                    if (w_wk[i]) begin
                        r_ent[i].vk <= bus.cdb_data;
                        r_ent[i].qk <= TAG_NONE;
                    end
                    if ((w_wj[i] || r_ent[i].qj == TAG_NONE) && (w_wk[i] || r_ent[i].qk == TAG_NONE))
                        r_ent[i].state <= ST_READY;
                end
        end
    end
endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed scoreboard bench; dispatches are checked by a monitor against a queue.
module tb_rs_bank;
    import rs_pkg::*;
    typedef struct packed {
        logic [5:0]  op;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [3:0]  tag;
        logic [9:0]  pc;
    } xact_t;
    logic  clk = 1'b0;
    logic  clr = 1'b0;
    int    n_chk = 0;
    int    n_pass = 0;
    xact_t sb[$];
    xact_t mon_act, mon_exp;
    rs_bank_if #(.DEPTH(4)) bus();
    rs_bank #(.DEPTH(4), .ID_BASE(1)) dut (.CLK(clk), .CLR(clr), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [5:0] op, input logic [15:0] v1, v2, input logic [3:0] tag, input logic [9:0] pc);
        sb.push_back('{op: op, v1: v1, v2: v2, tag: tag, pc: pc});
    endtask
    task automatic alloc(input logic [5:0] op, input logic [15:0] vj, vk, input logic [3:0] qj, qk,
                         input logic [9:0] pc, input logic [3:0] exp_tag);
        bus.alloc_op = op; bus.alloc_vj = vj; bus.alloc_vk = vk;
        bus.alloc_qj = qj; bus.alloc_qk = qk; bus.alloc_pc = pc;
        bus.alloc_valid = 1'b1;
        chk("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tag));
        tick();
        bus.alloc_valid = 1'b0;
    endtask
    task automatic cdb(input logic [3:0] tag, input logic [15:0] data);
        bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
        tick();
        bus.cdb_valid = 1'b0;
    endtask
    task automatic done(input logic [3:0] tag);
        bus.done_valid = 1'b1; bus.done_tag = tag;
        tick();
        bus.done_valid = 1'b0;
    endtask
    task automatic issue(input int n);
        bus.issue_ready = 1'b1;
        repeat (n) tick();
        bus.issue_ready = 1'b0;
    endtask
    always @(negedge clk) begin
        if (clr && bus.issue_valid && bus.issue_ready) begin
            mon_act = '{op: bus.issue_op, v1: bus.issue_v1, v2: bus.issue_v2, tag: bus.issue_tag, pc: bus.issue_pc};
            n_chk++;
            if (sb.size() == 0) $display("FAIL issue_unexpected: got %h expected none", mon_act);
            else begin
                mon_exp = sb.pop_front();
                if (mon_act === mon_exp) n_pass++;
                else $display("FAIL issue_xact: got %h expected %h", mon_act, mon_exp);
            end
        end
    end
    initial begin
        bus.alloc_valid = 0; bus.alloc_op = 0; bus.alloc_vj = 0; bus.alloc_vk = 0;
        bus.alloc_qj = 0; bus.alloc_qk = 0; bus.alloc_pc = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.issue_ready = 0; bus.done_valid = 0; bus.done_tag = 0;
`ifdef RS_FLUSH_EN
        bus.flush = 0;
`endif
        #12;
        chk("rst_busy", 32'(bus.busy_vec), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
        chk("rst_issue_v1", 32'(bus.issue_v1), 0);
        tick();
        clr = 1'b1;
        // simple ready instruction
        alloc(6'h05, 16'd3, 16'd4, 0, 0, 10'd1, 4'd1);
        chk("t1_issue_valid", 32'(bus.issue_valid), 1);
        push(6'h05, 16'd3, 16'd4, 4'd1, 10'd1);
        issue(1);
        done(1);
        chk("t1_count", 32'(bus.count), 0);
        // wakeup through the CDB
        alloc(6'h11, 16'd0, 16'd2, 4'd7, 0, 10'd20, 4'd1);
        chk("t2_wait", 32'(bus.issue_valid), 0);
        tick();
        cdb(4'd7, 16'h00AA);
        chk("t2_woken", 32'(bus.issue_valid), 1);
        push(6'h11, 16'h00AA, 16'd2, 4'd1, 10'd20);
        issue(1);
        done(1);
        // same-edge bypass
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 16'd9;
        alloc(6'h12, 16'd8, 16'd0, 0, 4'd5, 10'd30, 4'd1);
        bus.cdb_valid = 1'b0;
        chk("t3_bypass", 32'(bus.issue_valid), 1);
        push(6'h12, 16'd8, 16'd9, 4'd1, 10'd30);
        issue(1);
        done(1);
        // fill, full behaviour, done/alloc overlap, age ordering
        alloc(6'h21, 16'd0, 16'd100, 4'd9, 0, 10'd41, 4'd1);
        alloc(6'h22, 16'd0, 16'd200, 4'd10, 0, 10'd42, 4'd2);
        alloc(6'h23, 16'd0, 16'd300, 4'd9, 0, 10'd43, 4'd3);
        alloc(6'h24, 16'd0, 16'd400, 4'd9, 0, 10'd44, 4'd4);
        chk("t4_full_ready", 32'(bus.alloc_ready), 0);
        chk("t4_full_count", 32'(bus.count), 4);
        chk("t4_full_busy", 32'(bus.busy_vec), 32'hF);
        chk("t4_none_ready", 32'(bus.issue_valid), 0);
        bus.alloc_valid = 1'b1; bus.alloc_qj = 0;
        tick();
        bus.alloc_valid = 1'b0;
        chk("t4_ignored_alloc", 32'(bus.count), 4);
        done(3);
        chk("t4_done_nonissued", 32'(bus.count), 4);
        cdb(4'd10, 16'h0BBB);
        push(6'h22, 16'h0BBB, 16'd200, 4'd2, 10'd42);
        issue(1);
        chk("t4_issued_busy", 32'(bus.count), 4);
        bus.done_valid = 1'b1; bus.done_tag = 4'd2; bus.alloc_valid = 1'b1;
        tick();
        bus.done_valid = 1'b0; bus.alloc_valid = 1'b0;
        chk("t4_done_alloc_count", 32'(bus.count), 3);
        chk("t4_freed_ready", 32'(bus.alloc_ready), 1);
        alloc(6'h25, 16'd0, 16'd500, 4'd9, 0, 10'd45, 4'd2);
        cdb(4'd9, 16'h0CCC);
        push(6'h21, 16'h0CCC, 16'd100, 4'd1, 10'd41);
        push(6'h23, 16'h0CCC, 16'd300, 4'd3, 10'd43);
        push(6'h24, 16'h0CCC, 16'd400, 4'd4, 10'd44);
        push(6'h25, 16'h0CCC, 16'd500, 4'd2, 10'd45);
        issue(4);
        done(1); done(3); done(4); done(2);
        chk("t4_drained", 32'(bus.count), 0);
        // older waiting entry overtaken, then issued after wakeup
        alloc(6'h31, 16'd0, 16'd5, 4'd12, 0, 10'd51, 4'd1);
        alloc(6'h32, 16'd6, 16'd7, 0, 0, 10'd52, 4'd2);
        push(6'h32, 16'd6, 16'd7, 4'd2, 10'd52);
        issue(1);
        cdb(4'd12, 16'h0055);
        push(6'h31, 16'h0055, 16'd5, 4'd1, 10'd51);
        issue(1);
        done(2);
        chk("t5_one_left", 32'(bus.count), 1);
        done(1);
        chk("t5_empty", 32'(bus.count), 0);
        // asynchronous reset with an issued entry and a pending offer
        alloc(6'h41, 16'd1, 16'd2, 0, 0, 10'd61, 4'd1);
        push(6'h41, 16'd1, 16'd2, 4'd1, 10'd61);
        issue(1);
        alloc(6'h42, 16'd3, 16'd4, 0, 0, 10'd62, 4'd2);
        chk("t6_offer", 32'(bus.issue_valid), 1);
        #2 clr = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy_vec), 0);
        chk("t6_issue_valid", 32'(bus.issue_valid), 0);
        chk("t6_issue_v1", 32'(bus.issue_v1), 0);
        chk("t6_alloc_tag", 32'(bus.alloc_tag), 1);
        tick();
        clr = 1'b1;
        alloc(6'h43, 16'd7, 16'd8, 0, 0, 10'd63, 4'd1);
        push(6'h43, 16'd7, 16'd8, 4'd1, 10'd63);
        issue(1);
        done(1);
        chk("t6_after_reset", 32'(bus.count), 0);
`ifdef RS_FLUSH_EN
        alloc(6'h44, 16'd1, 16'd1, 0, 0, 10'd70, 4'd1);
        alloc(6'h45, 16'd2, 16'd2, 4'd9, 0, 10'd71, 4'd2);
        bus.flush = 1'b1; bus.alloc_valid = 1'b1;
        tick();
        bus.flush = 1'b0; bus.alloc_valid = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_issue_valid", 32'(bus.issue_valid), 0);
`endif
        tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
